// File: rtl/ram_sync_wait_c_if.sv
// MOV/MOC handshake bundle between the control unit (master) and the data RAM (slave).
interface ram_sync_wait_c_if;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] DataIn;
  logic [31:0] Address;
  logic        MOCoff;
  logic        MOC;
  logic [31:0] DataOut;
  logic        ERR;

  modport master (
    output MOV, ReadWrite, MS_2_0, DataIn, Address, MOCoff,
    input  MOC, DataOut, ERR
  );

  modport slave (
    input  MOV, ReadWrite, MS_2_0, DataIn, Address, MOCoff,
    output MOC, DataOut, ERR
  );
endinterface

// File: rtl/ram_sync_wait_c.sv
// Big-endian byte-addressed data RAM with MOV/MOC handshake, programmable wait states and sized access.
// Define RAM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses on ERR instead of force-aligning them.
module ram_sync_wait_c #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  ram_sync_wait_c_if.slave   bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [2:0]          ms_q, ms_d;
  logic [31:0]         din_q, din_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                moc_q, moc_d;
  logic [31:0]         dout_q, dout_d;
  logic                err_q, err_d;

  logic                mem_we_c;
  logic                misalign_c;
  logic [ADDR_W-1:0]   a0_c, a1_c, a2_c, a3_c;
  logic [7:0]          b0_c, b1_c, b2_c, b3_c;
  logic [31:0]         rdata_c;
  logic                unused_addr_hi;

  logic [7:0]          mem [DEPTH];

  // Address bits above ADDR_W are ignored so the address wraps modulo DEPTH.
  assign unused_addr_hi = ^bus.Address[31:ADDR_W];

  // Byte lanes, most significant first, from the size-aligned base.
  always_comb begin
    a0_c = addr_q;
    case (ms_q[1:0])
      2'b01:   a0_c = {addr_q[ADDR_W-1:1], 1'b0};
      2'b10:   a0_c = {addr_q[ADDR_W-1:2], 2'b00};
      default: a0_c = addr_q;
    endcase
    a1_c = a0_c + ADDR_W'(1);
    a2_c = a0_c + ADDR_W'(2);
    a3_c = a0_c + ADDR_W'(3);
  end

  assign b0_c = mem[a0_c];
  assign b1_c = mem[a1_c];
  assign b2_c = mem[a2_c];
  assign b3_c = mem[a3_c];

  // Read assembly with optional sign extension from the top assembled byte.
  always_comb begin
    case (ms_q[1:0])
      2'b00:   rdata_c = {{24{ms_q[2] & b0_c[7]}}, b0_c};
      2'b01:   rdata_c = {{16{ms_q[2] & b0_c[7]}}, b0_c, b1_c};
      default: rdata_c = {b0_c, b1_c, b2_c, b3_c};
    endcase
  end

`ifdef RAM_MISALIGN_TRAP_EN
  assign misalign_c = ((ms_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((ms_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Handshake next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    ms_d     = ms_q;
    din_d    = din_q;
    addr_d   = addr_q;
    moc_d    = moc_q;
    dout_d   = dout_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        moc_d = 1'b0;
        err_d = 1'b0;
        if (bus.MOV && !bus.MOCoff) begin
          rw_d    = bus.ReadWrite;
          ms_d    = bus.MS_2_0;
          din_d   = bus.DataIn;
          addr_d  = bus.Address[ADDR_W-1:0];
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.MOCoff) begin
          moc_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          moc_d   = 1'b1;
          state_d = DONE;
          if (ms_q[1:0] != 2'b11) begin
            if (misalign_c)  err_d    = 1'b1;
            else if (rw_q)   dout_d   = rdata_c;
            else             mem_we_c = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.MOV || bus.MOCoff) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      ms_q    <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      moc_q   <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      ms_q    <= ms_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      moc_q   <= moc_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; all bytes of one access commit on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      case (ms_q[1:0])
        2'b00: mem[a0_c] <= din_q[7:0];
        2'b01: begin
          mem[a0_c] <= din_q[15:8];
          mem[a1_c] <= din_q[7:0];
        end
        default: begin
          mem[a0_c] <= din_q[31:24];
          mem[a1_c] <= din_q[23:16];
          mem[a2_c] <= din_q[15:8];
          mem[a3_c] <= din_q[7:0];
        end
      endcase
    end
  end

  assign bus.MOC     = moc_q;
  assign bus.DataOut = dout_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_ram_sync_wait_c.sv
// Directed bench for ram_sync_wait_c: vector table on a zero-wait instance plus handshake corner cases on a 3-wait instance.
module tb_ram_sync_wait_c;

`ifdef RAM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_sync_wait_c_if if0();
  ram_sync_wait_c_if if3();

  ram_sync_wait_c #(.DEPTH(256), .WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  ram_sync_wait_c #(.DEPTH(256), .WAIT_STATES(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [2:0]  ms;
    logic [31:0] din;
    logic [31:0] addr;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic mov, input logic rw, input logic [2:0] ms,
                         input logic [31:0] din, input logic [31:0] addr);
    if (sel == 0) begin
      if0.MOV = mov; if0.ReadWrite = rw; if0.MS_2_0 = ms; if0.DataIn = din; if0.Address = addr;
    end else begin
      if3.MOV = mov; if3.ReadWrite = rw; if3.MS_2_0 = ms; if3.DataIn = din; if3.Address = addr;
    end
  endtask

  task automatic set_off(input int sel, input logic v);
    if (sel == 0) if0.MOCoff = v;
    else          if3.MOCoff = v;
  endtask

  task automatic get_rsp(input int sel, output logic moc, output logic [31:0] dout, output logic err);
    if (sel == 0) begin moc = if0.MOC; dout = if0.DataOut; err = if0.ERR; end
    else          begin moc = if3.MOC; dout = if3.DataOut; err = if3.ERR; end
  endtask

  // One full handshake; inputs are scrambled after the sampling edge to prove they were latched.
  task automatic run_op(input int sel, input string name, input logic rw, input logic [2:0] ms,
                        input logic [31:0] din, input logic [31:0] addr, input int exp_lat,
                        output logic [31:0] dout, output logic err);
    int n;
    logic moc;
    logic [31:0] d;
    logic e;
    @(negedge clk);
    set_req(sel, 1'b1, rw, ms, din, addr);
    n = 0;
    moc = 1'b0;
    while (!moc && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) set_req(sel, 1'b1, ~rw, ms ^ 3'b001, ~din, addr ^ 32'h0000_00C4);
      @(negedge clk);
      get_rsp(sel, moc, d, e);
    end
    chk({name, " latency"}, moc ? 32'(n) : 32'(0), 32'(exp_lat));
    dout = d;
    err  = e;
    @(posedge clk);
    @(negedge clk);
    get_rsp(sel, moc, d, e);
    chk({name, " moc held"}, 32'(moc), 32'(1));
    set_req(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    get_rsp(sel, moc, d, e);
    chk({name, " moc drop"}, 32'(moc), 32'(0));
    chk({name, " err clear"}, 32'(e), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic        m;
    logic        seen;

    // rw, ms, din, addr, expected DataOut after op, expected ERR in DONE
    vecs[0]  = '{1'b0, 3'b010, 32'h1122_3344, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 3'b010, 32'h0,         32'h0000_0000, 32'h1122_3344, 1'b0};
    vecs[2]  = '{1'b1, 3'b101, 32'h0,         32'h0000_0002, 32'h0000_3344, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_1234, 32'h0000_0020, 32'h0000_3344, 1'b0};
    vecs[4]  = '{1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_3344, 1'b0};
    vecs[5]  = '{1'b1, 3'b100, 32'h0,         32'h0000_0010, 32'hFFFF_FFDE, 1'b0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0,         32'h0000_0013, 32'h0000_00EF, 1'b0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0,         32'h0000_0012, 32'h0000_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 3'b101, 32'h0,         32'h0000_0012, 32'hFFFF_BEEF, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 32'h0000_8001, 32'h0000_0021, 32'hFFFF_BEEF, TRAP};
    vecs[10] = '{1'b1, 3'b101, 32'h0,         32'h0000_0020, TRAP ? 32'h0000_1234 : 32'hFFFF_8001, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 32'h0,         32'h0000_0021, TRAP ? 32'h0000_0034 : 32'h0000_0001, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_00A5, 32'h0000_0105, TRAP ? 32'h0000_0034 : 32'h0000_0001, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 32'h0,         32'h0000_0005, 32'h0000_00A5, 1'b0};
    vecs[14] = '{1'b1, 3'b011, 32'h0,         32'h0000_0000, 32'h0000_00A5, 1'b0};
    vecs[15] = '{1'b0, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_00A5, 1'b0};
    vecs[16] = '{1'b1, 3'b010, 32'h0,         32'h0000_0000, 32'h1122_3344, 1'b0};
    vecs[17] = '{1'b1, 3'b010, 32'h0,         32'h0000_0001, 32'h1122_3344, TRAP};
    vecs[18] = '{1'b1, 3'b110, 32'h0,         32'h0000_0003, 32'h1122_3344, TRAP};

    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_off(0, 1'b0);
    set_off(3, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      get_rsp(s == 0 ? 0 : 3, m, d, e);
      chk($sformatf("reset moc dut%0d", s), 32'(m), 32'(0));
      chk($sformatf("reset dout dut%0d", s), d, 32'h0);
      chk($sformatf("reset err dut%0d", s), 32'(e), 32'(0));
    end

    for (int i = 0; i < 19; i++) begin
      run_op(0, $sformatf("vec%0d", i), vecs[i].rw, vecs[i].ms, vecs[i].din, vecs[i].addr, 2, d, e);
      chk($sformatf("vec%0d dout", i), d, vecs[i].exp_dout);
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // Three wait states: MOC after five edges, held while MOV stays high.
    run_op(3, "ws3 write", 1'b0, 3'b010, 32'hCAFE_F00D, 32'h0000_0030, 5, d, e);
    run_op(3, "ws3 read", 1'b1, 3'b010, 32'h0, 32'h0000_0030, 5, d, e);
    chk("ws3 read dout", d, 32'hCAFE_F00D);

    // MOCoff during BUSY aborts the write before it commits.
    run_op(3, "pre write", 1'b0, 3'b000, 32'h0000_0011, 32'h0000_0040, 5, d, e);
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, 3'b000, 32'h0000_0055, 32'h0000_0040);
    @(posedge clk);
    @(negedge clk);
    set_off(3, 1'b1);
    set_req(3, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0000_0040);
    @(posedge clk);
    @(negedge clk);
    set_off(3, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      get_rsp(3, m, d, e);
      seen = seen | m;
    end
    chk("abort moc low", 32'(seen), 32'(0));
    run_op(3, "post abort read", 1'b1, 3'b000, 32'h0, 32'h0000_0040, 5, d, e);
    chk("post abort dout", d, 32'h0000_0011);

    // MOCoff in DONE drops MOC even with MOV still high.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0000_0010);
    repeat (2) @(posedge clk);
    @(negedge clk);
    get_rsp(0, m, d, e);
    chk("done moc", 32'(m), 32'(1));
    chk("done dout", d, 32'hDEAD_BEEF);
    set_off(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    get_rsp(0, m, d, e);
    chk("mocoff in done", 32'(m), 32'(0));
    set_off(0, 1'b0);
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);

    // Reset mid-operation clears outputs but keeps memory.
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0000_0030);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      get_rsp(3, m, d, e);
      seen = seen | m;
    end
    chk("midop reset moc", 32'(seen), 32'(0));
    chk("midop reset dout", d, 32'h0);
    run_op(3, "after reset read", 1'b1, 3'b010, 32'h0, 32'h0000_0030, 5, d, e);
    chk("mem kept over reset", d, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
